// File: rtl/nes_pad_emulator.sv
// nes_pad_emulator: APB3 peripheral that behaves like a 4021-based NES game
// pad. Software writes an 8-bit button image. The host's latch_in/clk_in
// strobes are synchronised into PCLK. The image is then shifted out on data_out.
module nes_pad_emulator #(
  parameter logic ACTIVE_LOW = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        latch_in,
  input  logic        clk_in,
  output logic        data_out
);

  localparam logic [7:0] ADDR_BUTTONS = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [3:0] IDX_DONE     = 4'd8;

  // Software-visible registers
  logic [7:0]  buttons_q, buttons_d;
  logic        en_q, en_d;
  logic        fill_q, fill_d;

  // Host strobe synchronisers: s1/s2 resynchronise, s3 is the edge reference
  logic        latch_s1_q, latch_s2_q, latch_s3_q;
  logic        clk_s1_q, clk_s2_q, clk_s3_q;

  // Shift engine state
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic        done_q, done_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        data_out_q, data_out_d;

  logic        apb_wr;
  logic        latch_fall;
  logic        clk_rise;
  logic        logic_bit;

  // Only the low byte of PWDATA carries register content
  logic        unused_pwdata;
  assign unused_pwdata = ^PWDATA[31:8];

  // Maps the logical (1 = pressed) bit onto the wire level
  function automatic logic pad_level(input logic b);
    return ACTIVE_LOW ? ~b : b;
  endfunction

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign data_out = data_out_q;

  assign apb_wr     = PSEL & PENABLE & PWRITE;
  assign latch_fall = latch_s3_q & ~latch_s2_q;
  assign clk_rise   = clk_s2_q & ~clk_s3_q;

  // APB register write decode
  always_comb begin
    buttons_d = buttons_q;
    en_d      = en_q;
    fill_d    = fill_q;
    if (apb_wr) begin
      if (PADDR == ADDR_BUTTONS) begin
        buttons_d = PWDATA[7:0];
      end
      if (PADDR == ADDR_CTRL) begin
        en_d   = PWDATA[0];
        fill_d = PWDATA[1];
      end
    end
  end

  // Shift engine next state: latch-high load dominates, then clock shifts
  always_comb begin
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    done_d     = done_q;
    poll_cnt_d = poll_cnt_q;
    if (latch_fall) begin
      poll_cnt_d = poll_cnt_q + 16'd1;
    end
    if (latch_s2_q) begin
      // Parallel-load mode: transparent to the current button image
      shift_d   = buttons_q;
      bit_idx_d = 4'd0;
      done_d    = 1'b0;
    end else if (clk_rise && !latch_fall && (bit_idx_q < IDX_DONE)) begin
      // A clock edge coinciding with the latch release is dropped
      shift_d   = {fill_q, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 4'd1;
      if (bit_idx_q == 4'd7) begin
        done_d = 1'b1;
      end
    end
  end

  // Serial output level: not-pressed while disabled, fill once exhausted
  always_comb begin
    logic_bit  = en_q & ((bit_idx_q == IDX_DONE) ? fill_q : shift_q[0]);
    data_out_d = pad_level(logic_bit);
  end

  // APB read-back mux; unmapped addresses read as zero
  always_comb begin
    PRDATA = 32'd0;
    case (PADDR)
      ADDR_BUTTONS: PRDATA = {24'd0, buttons_q};
      ADDR_STATUS:  PRDATA = {11'd0, done_q, bit_idx_q, poll_cnt_q};
      ADDR_CTRL:    PRDATA = {30'd0, fill_q, en_q};
      default:      PRDATA = 32'd0;
    endcase
  end

  // Two-flop synchronisers plus edge-reference flop for both host strobes
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      latch_s1_q <= 1'b0;
      latch_s2_q <= 1'b0;
      latch_s3_q <= 1'b0;
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_s3_q   <= 1'b0;
    end else begin
      latch_s1_q <= latch_in;
      latch_s2_q <= latch_s1_q;
      latch_s3_q <= latch_s2_q;
      clk_s1_q   <= clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
    end
  end

  // Register, shift engine and output register update
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      buttons_q  <= 8'h00;
      en_q       <= 1'b0;
      fill_q     <= 1'b1;
      shift_q    <= 8'h00;
      bit_idx_q  <= IDX_DONE;
      done_q     <= 1'b0;
      poll_cnt_q <= 16'd0;
      data_out_q <= pad_level(1'b0);
    end else begin
      buttons_q  <= buttons_d;
      en_q       <= en_d;
      fill_q     <= fill_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      done_q     <= done_d;
      poll_cnt_q <= poll_cnt_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Directed testbench for nes_pad_emulator (ACTIVE_LOW = 1).
module tb_nes_pad_emulator;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        latch_in;
  logic        clk_in;
  logic        data_out;

  int          n_tests;
  int          n_fail;
  logic [31:0] rd;
  logic [7:0]  exp_a5;

  nes_pad_emulator #(.ACTIVE_LOW(1'b1)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .latch_in (latch_in),
    .clk_in   (clk_in),
    .data_out (data_out)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic host_wait(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic latch_pulse();
    @(negedge PCLK);
    latch_in = 1'b1;
    host_wait(6);
    latch_in = 1'b0;
    host_wait(6);
  endtask

  task automatic clk_pulse();
    @(negedge PCLK);
    clk_in = 1'b1;
    host_wait(6);
    clk_in = 1'b0;
    host_wait(6);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    PRESET   = 1'b1;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = 8'h00;
    PWDATA   = 32'd0;
    latch_in = 1'b0;
    clk_in   = 1'b0;
    // Wire levels after clock k for image 0xA5 (active low): ~0xA5
    exp_a5   = 8'h5A;
    host_wait(3);
    PRESET = 1'b0;

    // Reset state
    check("rst_data_out", {31'd0, data_out}, 32'd1);
    check("rst_pready", {31'd0, PREADY}, 32'd1);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    apb_read(8'h00, rd); check("rst_buttons", rd, 32'h0000_0000);
    apb_read(8'h04, rd); check("rst_status", rd, 32'h0008_0000);
    apb_read(8'h08, rd); check("rst_ctrl", rd, 32'h0000_0002);

    // Frame 1: image 0xA5, enabled, fill = 1
    apb_write(8'h00, 32'h0000_00A5);
    apb_write(8'h08, 32'h0000_0003);
    apb_read(8'h00, rd); check("rb_buttons", rd, 32'h0000_00A5);
    apb_read(8'h08, rd); check("rb_ctrl", rd, 32'h0000_0003);
    latch_pulse();
    check("f1_bit0", {31'd0, data_out}, {31'd0, exp_a5[0]});
    // First clock: output must change on exactly the 4th PCLK edge
    @(negedge PCLK);
    clk_in = 1'b1;
    host_wait(3);
    check("lat_edge3", {31'd0, data_out}, {31'd0, exp_a5[0]});
    host_wait(1);
    check("lat_edge4", {31'd0, data_out}, {31'd0, exp_a5[1]});
    host_wait(2);
    clk_in = 1'b0;
    host_wait(6);
    for (int k = 2; k < 8; k++) begin
      clk_pulse();
      check($sformatf("f1_bit%0d", k), {31'd0, data_out}, {31'd0, exp_a5[k]});
    end
    for (int k = 8; k < 11; k++) begin
      clk_pulse();
      check($sformatf("f1_fill_clk%0d", k), {31'd0, data_out}, 32'd0);
    end
    apb_read(8'h04, rd); check("f1_status", rd, 32'h0018_0001);

    // Frame 2: BUTTONS rewritten after the 3rd clock must not disturb it
    latch_pulse();
    check("f2_bit0", {31'd0, data_out}, {31'd0, exp_a5[0]});
    for (int k = 1; k < 4; k++) clk_pulse();
    apb_write(8'h00, 32'h0000_00FF);
    for (int k = 4; k < 8; k++) begin
      clk_pulse();
      check($sformatf("f2_old_bit%0d", k), {31'd0, data_out}, {31'd0, exp_a5[k]});
    end
    apb_read(8'h04, rd); check("f2_status_mid", rd, 32'h0007_0002);
    clk_pulse();

    // Frame 3: new image 0xFF; latch release coincides with a clock rise
    @(negedge PCLK);
    latch_in = 1'b1;
    host_wait(6);
    latch_in = 1'b0;
    clk_in   = 1'b1;
    host_wait(6);
    apb_read(8'h04, rd); check("f3_simul_edge", rd, 32'h0000_0003);
    clk_in = 1'b0;
    host_wait(6);
    check("f3_bit0", {31'd0, data_out}, 32'd0);
    for (int k = 1; k < 9; k++) begin
      clk_pulse();
      check($sformatf("f3_clk%0d", k), {31'd0, data_out}, 32'd0);
    end
    apb_read(8'h04, rd); check("f3_status", rd, 32'h0018_0003);

    // Frame 4: disabled -> not-pressed level, poll count keeps running
    apb_write(8'h08, 32'h0000_0000);
    latch_pulse();
    check("f4_bit0", {31'd0, data_out}, 32'd1);
    for (int k = 1; k < 9; k++) begin
      clk_pulse();
      check($sformatf("f4_clk%0d", k), {31'd0, data_out}, 32'd1);
    end
    apb_read(8'h04, rd); check("f4_status", rd, 32'h0018_0004);

    // poll_cnt wrap from 0xFFFF
    @(negedge PCLK);
    force dut.poll_cnt_q = 16'hFFFF;
    @(negedge PCLK);
    release dut.poll_cnt_q;
    apb_read(8'h04, rd); check("wrap_pre", rd, 32'h0018_FFFF);
    latch_pulse();
    apb_read(8'h04, rd); check("wrap_post", rd, 32'h0000_0000);

    // Reset in the middle of a shift sequence
    apb_write(8'h08, 32'h0000_0003);
    latch_pulse();
    for (int k = 0; k < 4; k++) clk_pulse();
    apb_read(8'h04, rd); check("mid_status", rd, 32'h0004_0001);
    check("mid_data_out", {31'd0, data_out}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b1;
    PADDR  = 8'h04;
    @(negedge PCLK);
    check("rst2_status", PRDATA, 32'h0008_0000);
    check("rst2_data_out", {31'd0, data_out}, 32'd1);
    PRESET = 1'b0;
    apb_read(8'h00, rd); check("rst2_buttons", rd, 32'h0000_0000);
    apb_read(8'h08, rd); check("rst2_ctrl", rd, 32'h0000_0002);
    apb_read(8'h0C, rd); check("unmapped", rd, 32'h0000_0000);
    check("end_pready", {31'd0, PREADY}, 32'd1);
    check("end_pslverr", {31'd0, PSLVERR}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
